mux_arbiter: RTL and testbench

//   Round-robin arbiter that shares a 2:1 data mux between two requesters (A, B).

---
 rtl/mux_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing a 2:1 data mux between requesters A and B.
// Optional hold limit forces a handover while the other side is waiting.
module mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic           FORCE_EN  = (MAX_HOLD > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [HCW-1:0] r_hold_cnt;
  logic           r_last_b;
  logic           r_gnt_a;
  logic           r_gnt_b;
  logic           r_sel;
  logic           w_other_req;
  logic           w_hold_expired;

  assign w_hold_expired = FORCE_EN && (r_hold_cnt == HOLD_LAST);

  // Next-state selection; unused encodings fall back to IDLE.
  always_comb begin
    w_next      = r_state;
    w_other_req = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) begin
          w_next = r_last_b ? GNT_A : GNT_B;
        end else if (req_a) begin
          w_next = GNT_A;
        end else if (req_b) begin
          w_next = GNT_B;
        end else begin
          w_next = IDLE;
        end
      end
      GNT_A: begin
        w_other_req = req_b;
        if (!req_a) begin
          w_next = req_b ? GNT_B : IDLE;
        end else if (req_b && w_hold_expired) begin
          w_next = GNT_B;
        end else begin
          w_next = GNT_A;
        end
      end
      GNT_B: begin
        w_other_req = req_a;
        if (!req_b) begin
          w_next = req_a ? GNT_A : IDLE;
        end else if (req_a && w_hold_expired) begin
          w_next = GNT_A;
        end else begin
          w_next = GNT_B;
        end
      end
      default: begin
        w_next      = IDLE;
        w_other_req = 1'b0;
      end
    endcase
  end

  // State, hold counter, round-robin pointer and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_last_b   <= 1'b1;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_sel      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt_a <= (w_next == GNT_A);
      r_gnt_b <= (w_next == GNT_B);
      r_sel   <= (w_next == GNT_B);

      // Counter only runs while the other side waits, so a lone owner is never preempted.
      if ((w_next != r_state) || (w_next == IDLE)) begin
        r_hold_cnt <= '0;
      end else if (w_other_req && (r_hold_cnt != HOLD_MAX)) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end else begin
        r_hold_cnt <= r_hold_cnt;
      end

      if ((w_next != r_state) && (w_next == GNT_A)) begin
        r_last_b <= 1'b0;
      end else if ((w_next != r_state) && (w_next == GNT_B)) begin
        r_last_b <= 1'b1;
      end else begin
        r_last_b <= r_last_b;
      end
    end
  end

  assign gnt_a   = r_gnt_a;
  assign gnt_b   = r_gnt_b;
  assign sel     = r_sel;
  assign y_valid = r_gnt_a | r_gnt_b;
  assign y       = r_sel ? b : a;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed, table-driven bench for mux_arbiter: one instance with unlimited
// hold and one with MAX_HOLD=4, sharing the same stimulus.
module tb_mux_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic [7:0] a;
  logic [7:0] b;

  logic       gnt_a0, gnt_b0, sel0, y_valid0;
  logic [7:0] y0;
  logic       gnt_a4, gnt_b4, sel4, y_valid4;
  logic [7:0] y4;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a0), .gnt_b(gnt_b0), .sel(sel0), .y(y0), .y_valid(y_valid0)
  );

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a4), .gnt_b(gnt_b4), .sel(sel4), .y(y4), .y_valid(y_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ra;
    logic       rb;
    logic [7:0] da;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       s;
    logic [7:0] yy;
    logic       v;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic ga, input logic gb, input logic s,
                      input logic [7:0] yy, input logic v);
    chk({tag, ".gnt_a"}, 32'(gnt_a0), 32'(ga));
    chk({tag, ".gnt_b"}, 32'(gnt_b0), 32'(gb));
    chk({tag, ".sel"}, 32'(sel0), 32'(s));
    chk({tag, ".y"}, 32'(y0), 32'(yy));
    chk({tag, ".y_valid"}, 32'(y_valid0), 32'(v));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    //            ra    rb    a      b      ga    gb    sel   y      valid
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h5A, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1};

    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    a     = 8'hA5;
    b     = 8'h3C;
    #3;
    chk0("reset", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    step();
    chk0("reset_edge", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    rst = 1'b0;

    // Table: single requests, round-robin ties, direct handovers, re-requests.
    for (int i = 0; i < 15; i++) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      a     = vecs[i].da;
      b     = vecs[i].db;
      step();
      chk0($sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb, vecs[i].s, vecs[i].yy, vecs[i].v);
    end

    // Tie right after reset goes to A; dropping A hands over to B with no gap.
    req_a = 1'b0;
    req_b = 1'b0;
    a     = 8'hA5;
    b     = 8'h3C;
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    chk0("tie_first", 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
    req_a = 1'b0;
    step();
    chk0("handover", 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);

    // Hold limit 4 with both requests high: alternating 4-cycle grants.
    req_a = 1'b0;
    req_b = 1'b0;
    do_reset();
    req_a = 1'b1;
    req_b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("hold4_ga_%0d", k), 32'(gnt_a4), 32'((((k - 1) / 4) % 2) == 0));
      chk($sformatf("hold4_gb_%0d", k), 32'(gnt_b4), 32'((((k - 1) / 4) % 2) == 1));
      chk($sformatf("hold4_excl_%0d", k), 32'(gnt_a4 & gnt_b4), 32'(0));
      chk($sformatf("hold0_ga_%0d", k), 32'(gnt_a0), 32'(1));
    end

    // Lone requester B is never preempted under the hold limit.
    req_a = 1'b0;
    req_b = 1'b0;
    do_reset();
    req_b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("lone_b_%0d", k), 32'(gnt_b4), 32'(1));
      chk($sformatf("lone_sel_%0d", k), 32'(sel4), 32'(1));
    end

    // Asynchronous reset between edges while B holds the channel.
    rst = 1'b1;
    #1;
    chk("async_gb", 32'(gnt_b4), 32'(0));
    chk("async_sel", 32'(sel4), 32'(0));
    chk("async_valid", 32'(y_valid4), 32'(0));
    chk("async_y", 32'(y4), 32'(8'hA5));
    req_a = 1'b1;
    req_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_ga", 32'(gnt_a4), 32'(1));
    chk("post_rst_gb", 32'(gnt_b4), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
